// File: rtl/xmr_check_pkg.sv
// Shared types and constants for the cross-module latency checker.
package xmr_check_pkg;

   typedef enum logic [1:0] {IDLE, WARMUP, CHECK, FAIL} chk_state_t;

   localparam int HIST_DEPTH = 16;
   localparam int SRC_O      = 0;
   localparam int SRC_PROBE  = 1;

   function automatic int max_lat(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr_i is a synchronous clear with priority.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/xmr_latency_checker.sv
// Passive checker: O and the bound probe must reproduce I after fixed latencies.
// Attached through a bind next to the terminator; it only observes the bound design.
//
//   state  | meaning
//   IDLE   | disarmed, waiting for enable
//   WARMUP | history filling after arm, no compares
//   CHECK  | comparing both taps every enabled cycle
//   FAIL   | mismatch seen, still counting; only RESET leaves
module xmr_latency_checker
   import xmr_check_pkg::*;
#(
   parameter int O_LATENCY     = 2,
   parameter int PROBE_LATENCY = 1,
   parameter int CNT_W         = 8,
   parameter int CYC_W         = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             I,
   input  logic             O,
   input  logic             probe,
   input  logic             enable,
   output logic             checking,
   output logic             error,
   output logic [CNT_W-1:0] o_mismatch_cnt,
   output logic [CNT_W-1:0] p_mismatch_cnt,
   output logic [CYC_W-1:0] first_fail_cyc,
   output logic [1:0]       first_fail_src
);

   generate
      if (O_LATENCY < 1 || O_LATENCY > 15) begin : g_bad_o_latency
         $fatal(1, "xmr_latency_checker: O_LATENCY out of range 1..15");
      end
      if (PROBE_LATENCY < 1 || PROBE_LATENCY > 15) begin : g_bad_probe_latency
         $fatal(1, "xmr_latency_checker: PROBE_LATENCY out of range 1..15");
      end
   endgenerate

   localparam int WARM_LOAD = max_lat(O_LATENCY, PROBE_LATENCY);

   chk_state_t            state_q, state_d;
   logic [3:0]            warm_q, warm_d;
   logic [HIST_DEPTH-1:0] hist_q;
   logic [CYC_W-1:0]      cyc_q;
   logic                  checking_q;
   logic                  error_q;
   logic                  o_mis_q, p_mis_q;
   logic [CYC_W-1:0]      mis_cyc_q;
   logic [CYC_W-1:0]      ffc_q;
   logic [1:0]            ffs_q;

   logic                  cmp_en;
   logic                  o_mis, p_mis;
   logic [1:0]            src_now;
   logic                  unused_hist_msb;

   assign unused_hist_msb = hist_q[HIST_DEPTH-1];

   // FAIL keeps counting regardless of enable; CHECK pauses when enable is low.
   assign cmp_en = ((state_q == CHECK) && enable) || (state_q == FAIL);
   assign o_mis  = cmp_en && (O     != hist_q[O_LATENCY-1]);
   assign p_mis  = cmp_en && (probe != hist_q[PROBE_LATENCY-1]);

   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = WARMUP;
               warm_d  = 4'(WARM_LOAD);
            end
         end
         WARMUP: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (warm_q <= 4'd1) begin
               state_d = CHECK;
               warm_d  = '0;
            end else begin
               warm_d = warm_q - 4'd1;
            end
         end
         CHECK: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (o_mis || p_mis) begin
               state_d = FAIL;
            end
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      src_now            = '0;
      src_now[SRC_O]     = o_mis_q;
      src_now[SRC_PROBE] = p_mis_q;
   end

   // Compare results are registered first, so the reporting fields move one edge later.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         warm_q     <= '0;
         hist_q     <= '0;
         cyc_q      <= '0;
         checking_q <= 1'b0;
         error_q    <= 1'b0;
         o_mis_q    <= 1'b0;
         p_mis_q    <= 1'b0;
         mis_cyc_q  <= '0;
         ffc_q      <= '0;
         ffs_q      <= '0;
      end else begin
         state_q    <= state_d;
         warm_q     <= warm_d;
         hist_q     <= {hist_q[HIST_DEPTH-2:0], I};
         cyc_q      <= cyc_q + 1'b1;
         checking_q <= (state_d == CHECK);
         o_mis_q    <= o_mis;
         p_mis_q    <= p_mis;
         mis_cyc_q  <= cyc_q;
         if (o_mis_q || p_mis_q) begin
            error_q <= 1'b1;
            if (!error_q) begin
               ffc_q <= mis_cyc_q;
               ffs_q <= src_now;
            end
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_o_cnt (
      .clk_i (CLK),
      .clr_i (RESET),
      .inc_i (o_mis_q),
      .cnt_o (o_mismatch_cnt)
   );

   sat_counter #(.W(CNT_W)) u_p_cnt (
      .clk_i (CLK),
      .clr_i (RESET),
      .inc_i (p_mis_q),
      .cnt_o (p_mismatch_cnt)
   );

   assign checking       = checking_q;
   assign error          = error_q;
   assign first_fail_cyc = ffc_q;
   assign first_fail_src = ffs_q;

endmodule
